// File: rtl/fft_frame_sequencer.sv
// Streams fixed-size frames from a show-ahead FIFO into the FFT sink with Avalon-ST framing,
// throttles frames outstanding inside the FFT and captures the per-frame block exponent.
module fft_frame_sequencer #(
  parameter int SAMPLES      = 4096,
  parameter int CNT_W        = 13,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic             fft_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] fifo_usedw,
  input  logic [15:0]      fifo_q,
  output logic             fifo_rdreq,
  input  logic             sink_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [15:0]      sink_real,
  input  logic             src_valid,
  input  logic             src_sop,
  input  logic             src_eop,
  input  logic [5:0]       src_exp,
  output logic [5:0]       exp_out,
  output logic             exp_valid,
  output logic             busy,
  output logic [2:0]       inflight,
  output logic [15:0]      frames_sent,
  output logic             err
);

  localparam logic [CNT_W-1:0] LP_SAMPLES = CNT_W'(SAMPLES);
  localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(SAMPLES - 1);
  localparam logic [2:0]       LP_MAX_INF = 3'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_pos;
  logic [CNT_W-1:0] w_pos_next;
  logic [2:0]       r_inflight;
  logic [15:0]      r_frames_sent;
  logic [5:0]       r_exp_out;
  logic             r_exp_valid;
  logic             r_err;

  logic w_streaming;
  logic w_beat;
  logic w_last;
  logic w_eop_beat;
  logic w_start;
  logic w_inc;
  logic w_dec;
  logic w_orphan;
  logic w_underrun;
  logic w_src_sop;

  assign w_streaming = (r_state == S_STREAM);
  assign w_beat      = w_streaming && sink_ready;
  assign w_last      = (r_pos == LP_LAST);
  assign w_eop_beat  = w_beat && w_last;
  assign w_start     = enable && (fifo_usedw >= LP_SAMPLES) && (r_inflight < LP_MAX_INF);

  assign w_inc      = w_eop_beat;
  assign w_dec      = src_valid && src_eop;
  // An emitted frame with nothing recorded as in flight is a protocol violation.
  assign w_orphan   = w_dec && !w_inc && (r_inflight == 3'd0);
  assign w_underrun = w_beat && (fifo_usedw == '0);
  assign w_src_sop  = src_valid && src_sop;

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_beat) begin
          if (w_last) begin
            w_pos_next   = '0;
            w_state_next = S_IDLE;
          end else begin
            w_pos_next = r_pos + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_pos_next   = '0;
      end
    endcase
  end

  always_ff @(posedge fft_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pos         <= '0;
      r_inflight    <= 3'd0;
      r_frames_sent <= 16'd0;
      r_exp_out     <= 6'd0;
      r_exp_valid   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
      if (w_eop_beat) begin
        r_frames_sent <= r_frames_sent + 16'd1;
      end
      case ({w_inc, w_dec})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   if (r_inflight != 3'd0) r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
      r_exp_valid <= w_src_sop;
      if (w_src_sop) begin
        r_exp_out <= src_exp;
      end
      r_err <= r_err | w_orphan | w_underrun;
    end
  end

  assign sink_valid  = w_streaming;
  assign sink_sop    = w_streaming && (r_pos == '0);
  assign sink_eop    = w_streaming && w_last;
  assign sink_real   = fifo_q;
  assign fifo_rdreq  = w_beat;
  assign busy        = w_streaming;
  assign inflight    = r_inflight;
  assign frames_sent = r_frames_sent;
  assign exp_out     = r_exp_out;
  assign exp_valid   = r_exp_valid;
  assign err         = r_err;

endmodule
